// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and helpers for the line buffer ring sequencer.
// Holds the FSM state enum and a generic one-hot rotate used for write steering.
package line_buf_ctrl_pkg;

  localparam int MAX_LINES = 32;
  localparam int IDX_W     = $clog2(MAX_LINES);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    POP     = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } line_buf_ctrl_state_t;

  // Rotate the low 'lines' bits of a one-hot left by one, wrapping the top bit to bit 0.
  function automatic logic [MAX_LINES-1:0] rotlOneHot(input logic [MAX_LINES-1:0] vec,
                                                      input int lines);
    logic [MAX_LINES-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (i < lines) begin
        res[IDX_W'((i + 1) % lines)] = vec[IDX_W'(i)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Handshake bundle between the line buffer glue (master) and line_buf_ctrl (slave).
// The master drives the buffer status/strobes; the slave drives steering and control pulses.
interface line_buf_ctrl_if #(
  parameter int LINES_CNT = 3,
  parameter int CNT_WIDTH = 16
);

  localparam int OLD_W = $clog2(LINES_CNT);

  logic                 sof_i;
  logic                 in_eol_i;
  logic [LINES_CNT-1:0] empty_i;
  logic [LINES_CNT-1:0] unread_i;
  logic                 out_eol_i;
  logic [LINES_CNT-1:0] wr_sel_o;
  logic [LINES_CNT-1:0] pop_o;
  logic [LINES_CNT-1:0] flush_o;
  logic [OLD_W-1:0]     oldest_o;
  logic                 busy_o;
  logic [CNT_WIDTH-1:0] win_cnt_o;

  modport master (
    output sof_i, in_eol_i, empty_i, unread_i, out_eol_i,
    input  wr_sel_o, pop_o, flush_o, oldest_o, busy_o, win_cnt_o
  );

  modport slave (
    input  sof_i, in_eol_i, empty_i, unread_i, out_eol_i,
    output wr_sel_o, pop_o, flush_o, oldest_o, busy_o, win_cnt_o
  );

endinterface

// File: rtl/line_buf_ctrl.sv
// Sliding-window sequencer for a ring of LINES_CNT line buffers: steer, pop a window, release oldest.
// Window counter is built only when LINE_BUF_CTRL_WIN_CNT_EN is defined; otherwise win_cnt_o is 0.
module line_buf_ctrl
  import line_buf_ctrl_pkg::*;
#(
  parameter int LINES_CNT = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  line_buf_ctrl_if.slave     bus
);

  localparam int OLD_W = $clog2(LINES_CNT);

  line_buf_ctrl_state_t r_state, w_stateNext;
  logic [LINES_CNT-1:0] r_wrSel, w_wrSelNext, w_wrSelBase;
  logic [LINES_CNT-1:0] r_pop, w_popNext;
  logic [LINES_CNT-1:0] r_flush, w_flushNext;
  logic [OLD_W-1:0]     r_oldest, w_oldestNext, w_oldestInc;
  logic                 r_busy, w_busyNext;
  logic                 w_trigger;

  assign w_trigger   = (&(~bus.empty_i)) && (|bus.unread_i);
  assign w_oldestInc = (r_oldest == OLD_W'(LINES_CNT - 1)) ? '0 : r_oldest + 1'b1;

  // SOF restarts steering at buffer 0 before any same-cycle end-of-line rotation.
  assign w_wrSelBase = bus.sof_i ? LINES_CNT'(1) : r_wrSel;
  assign w_wrSelNext = bus.in_eol_i
                     ? LINES_CNT'(rotlOneHot(MAX_LINES'(w_wrSelBase), LINES_CNT))
                     : w_wrSelBase;

  always_comb begin
    w_stateNext  = r_state;
    w_popNext    = '0;
    w_flushNext  = '0;
    w_oldestNext = r_oldest;
    case (r_state)
      FILL: begin
        if (w_trigger) begin
          w_stateNext = POP;
          w_popNext   = '1;
        end
      end
      POP: begin
        w_stateNext = DRAIN;
      end
      DRAIN: begin
        if (bus.out_eol_i) begin
          w_stateNext = RELEASE;
          w_flushNext = LINES_CNT'(1) << r_oldest;
        end
      end
      RELEASE: begin
        w_stateNext  = FILL;
        w_oldestNext = w_oldestInc;
      end
      default: begin
        w_stateNext = FILL;
      end
    endcase
    if (bus.sof_i) begin
      w_stateNext  = FILL;
      w_popNext    = '0;
      w_flushNext  = '0;
      w_oldestNext = '0;
    end
  end

  assign w_busyNext = (w_stateNext != FILL);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= FILL;
      r_wrSel  <= LINES_CNT'(1);
      r_pop    <= '0;
      r_flush  <= '0;
      r_oldest <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_wrSel  <= w_wrSelNext;
      r_pop    <= w_popNext;
      r_flush  <= w_flushNext;
      r_oldest <= w_oldestNext;
      r_busy   <= w_busyNext;
    end
  end

`ifdef LINE_BUF_CTRL_WIN_CNT_EN
  logic [CNT_WIDTH-1:0] r_winCnt;

  // Counts completed windows since SOF; holds at all ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_winCnt <= '0;
    end else if (bus.sof_i) begin
      r_winCnt <= '0;
    end else if ((r_state == RELEASE) && (r_winCnt != '1)) begin
      r_winCnt <= r_winCnt + 1'b1;
    end
  end

  assign bus.win_cnt_o = r_winCnt;
`else
  assign bus.win_cnt_o = {CNT_WIDTH{1'b0}};
`endif

  assign bus.wr_sel_o = r_wrSel;
  assign bus.pop_o    = r_pop;
  assign bus.flush_o  = r_flush;
  assign bus.oldest_o = r_oldest;
  assign bus.busy_o   = r_busy;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Randomized bench for line_buf_ctrl against a timestamp-based window model and a simple buffer ring.
// Honours LINE_BUF_CTRL_WIN_CNT_EN for the expected window count.
module tb_line_buf_ctrl;

  localparam int N  = 3;
  localparam int CW = 3;

  logic clk;
  logic rst_n;

  line_buf_ctrl_if #(.LINES_CNT(N), .CNT_WIDTH(CW)) bus ();

  line_buf_ctrl #(.LINES_CNT(N), .CNT_WIDTH(CW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Window timeline: cycle of pop pulse, cycle of flush pulse, busy span [busyFrom, busyTo].
  int popAt, flushAt, busyFrom, busyTo;
  int wrIdx, oldest, cnt;
  bit [N-1:0] full, unread;

  function automatic bit expBusy();
    return (busyFrom >= 0) && (cyc >= busyFrom) && ((busyTo < 0) || (cyc <= busyTo));
  endfunction

  function automatic bit inDrain();
    return expBusy() && (busyTo < 0) && (cyc > popAt);
  endfunction

  task automatic modelReset();
    popAt = -1; flushAt = -1; busyFrom = -1; busyTo = -1;
    wrIdx = 0; oldest = 0; cnt = 0;
    full = '0; unread = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkAll();
    logic [31:0] expCnt;
`ifdef LINE_BUF_CTRL_WIN_CNT_EN
    expCnt = 32'(cnt);
`else
    expCnt = 32'd0;
`endif
    checkOutput("wr_sel",  32'(bus.wr_sel_o), 32'(1 << wrIdx));
    checkOutput("pop",     32'(bus.pop_o),    (cyc == popAt) ? 32'((1 << N) - 1) : 32'd0);
    checkOutput("flush",   32'(bus.flush_o),  (cyc == flushAt) ? 32'(1 << oldest) : 32'd0);
    checkOutput("oldest",  32'(bus.oldest_o), 32'(oldest));
    checkOutput("busy",    32'(bus.busy_o),   32'(expBusy()));
    checkOutput("win_cnt", 32'(bus.win_cnt_o), expCnt);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the model, check next cycle.
  task automatic applyStimulus(input bit s, input bit ie, input bit oe);
    bit trig, drain;
    if (!s && full[wrIdx]) ie = 1'b0;
    trig  = !s && !expBusy() && (&full) && (|unread);
    drain = !s && oe && inDrain();

    bus.sof_i     = s;
    bus.in_eol_i  = ie;
    bus.out_eol_i = oe;
    bus.empty_i   = ~full;
    bus.unread_i  = unread;

    if (s) begin
      full = '0; unread = '0;
      if (ie) begin full[0] = 1'b1; unread[0] = 1'b1; end
      wrIdx = ie ? 1 : 0;
      oldest = 0; cnt = 0;
      popAt = -1; flushAt = -1; busyFrom = -1; busyTo = -1;
    end else begin
      if (cyc == popAt) unread = '0;
      if (cyc == flushAt) full[oldest] = 1'b0;
      if (ie) begin
        full[wrIdx] = 1'b1; unread[wrIdx] = 1'b1;
        wrIdx = (wrIdx + 1) % N;
      end
      if (cyc == flushAt) begin
        oldest = (oldest + 1) % N;
        if (cnt < (1 << CW) - 1) cnt++;
      end
      if (trig) begin popAt = cyc + 1; busyFrom = cyc + 1; busyTo = -1; flushAt = -1; end
      if (drain) begin flushAt = cyc + 1; busyTo = cyc + 1; end
    end

    @(negedge clk);
    cyc++;
    checkAll();
  endtask

  task automatic applyReset();
    bus.sof_i = 1'b0; bus.in_eol_i = 1'b0; bus.out_eol_i = 1'b0;
    #2 rst_n = 1'b0;
    modelReset();
    bus.empty_i = '1; bus.unread_i = '0;
    #1 checkAll();
    @(negedge clk);
    cyc++;
    checkAll();
    rst_n = 1'b1;
  endtask

  task automatic sendLine(input int len);
    repeat (len - 1) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sof_i = 1'b0; bus.in_eol_i = 1'b0; bus.out_eol_i = 1'b0;
    bus.empty_i = '1; bus.unread_i = '0;
    modelReset();
    @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    // Fill three lines, drain the first window, then six more line/window rounds to wrap oldest.
    applyStimulus(1, 0, 0);
    repeat (3) sendLine(8);
    repeat (9) applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0);
    repeat (6) begin
      sendLine(8);
      repeat (9) applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 1);
      repeat (2) applyStimulus(0, 0, 0);
    end

    // SOF while a window drains, then a stray end-of-line that must be ignored.
    sendLine(8);
    repeat (4) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0);

    // Single-pixel line coinciding with SOF.
    applyStimulus(1, 1, 0);
    repeat (2) applyStimulus(0, 0, 0);

    // Asynchronous reset in the middle of a drain, then refill from scratch.
    applyStimulus(1, 0, 0);
    repeat (3) sendLine(5);
    repeat (4) applyStimulus(0, 0, 0);
    checkOutput("drain_reached", 32'(inDrain()), 32'd1);
    applyReset();
    repeat (2) sendLine(6);
    repeat (6) applyStimulus(0, 0, 0);
    sendLine(6);
    repeat (8) applyStimulus(0, 0, 1);

    // Random traffic: occasional SOF, random line gaps, drains plus stray end-of-lines.
    for (int i = 0; i < 4000; i++) begin
      bit s, ie, oe;
      s  = ($urandom_range(0, 299) == 0);
      ie = s ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      oe = inDrain() ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
      applyStimulus(s, ie, oe);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
